// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and framing constants for imem_loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 4;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// rtl/imem_loader_byte_assembler.sv - packs little-endian bytes into 32-bit words for header, data and trailer
module byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  r_cnt;
  logic [23:0] r_shift;

  // The fourth byte is combined combinationally so the word is usable in its own accept cycle.
  assign o_word_valid = i_byte_valid && (r_cnt == 2'(BYTES_PER_WORD - 1));
  assign o_word       = {i_byte, r_shift};

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (i_byte_valid) begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= {i_byte, r_shift[23:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time instruction memory writer; IMEM_LOADER_CHECKSUM_EN adds a sum trailer check
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter int INSTR_W    = 32,
  parameter int IMEM_DEPTH = 1024,
  parameter int BASE_ADDR  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_valid_i,
  input  logic [7:0]         rx_data_i,
  output logic               rx_ready_o,
  input  logic               start_i,
  output logic               imem_we_o,
  output logic [PC_W-1:0]    imem_waddr_o,
  output logic [INSTR_W-1:0] imem_wdata_o,
  output logic               cpu_reset_o,
  output logic               done_o,
  output logic               err_o
);

  loader_state_t      r_state;
  loader_state_t      w_state_nxt;
  logic               w_accept;
  logic               w_word_valid;
  logic [31:0]        w_word;
  logic               w_rearm;
  logic               w_hold_done;
  logic [PC_W-1:0]    r_idx;
  logic [PC_W-1:0]    r_last;
  logic               r_we;
  logic [PC_W-1:0]    r_waddr;
  logic [INSTR_W-1:0] r_wdata;
  logic               r_cpu_reset;
  logic               r_done;
  logic               r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]        r_sum;
`endif

  assign rx_ready_o  = !reset && (r_state == HDR || r_state == DATA || r_state == CSUM);
  assign w_accept    = rx_valid_i && rx_ready_o;
  assign w_rearm     = start_i && (r_state == DONE || r_state == ERR);
  assign w_hold_done = (r_state == DONE) && !start_i;

  byte_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_rearm),
    .i_byte_valid (w_accept),
    .i_byte       (rx_data_i),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HDR: begin
        if (w_word_valid) begin
          if (w_word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            w_state_nxt = CSUM;
`else
            w_state_nxt = DONE;
`endif
          end else if (w_word > 32'(IMEM_DEPTH)) begin
            w_state_nxt = ERR;
          end else begin
            w_state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (w_word_valid && (r_idx == r_last)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_state_nxt = CSUM;
`else
          w_state_nxt = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (w_word_valid) begin
          w_state_nxt = (w_word == r_sum) ? DONE : ERR;
        end
      end
`endif
      DONE, ERR: begin
        if (start_i) begin
          w_state_nxt = HDR;
        end
      end
      default: w_state_nxt = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= HDR;
      r_idx       <= '0;
      r_last      <= '0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_we        <= 1'b0;
      // Release the core one cycle after reaching DONE; an error is flagged as soon as it is decided.
      r_done      <= w_hold_done;
      r_cpu_reset <= !w_hold_done;
      r_err       <= (w_state_nxt == ERR);
      if (r_state == HDR && w_word_valid) begin
        r_idx  <= '0;
        r_last <= PC_W'(w_word - 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_sum  <= '0;
`endif
      end
      if (r_state == DATA && w_word_valid) begin
        r_we    <= 1'b1;
        r_waddr <= PC_W'(BASE_ADDR) + r_idx;
        r_wdata <= INSTR_W'(w_word);
        r_idx   <= r_idx + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_sum   <= r_sum + w_word;
`endif
      end
      if (w_rearm) begin
        r_idx <= '0;
      end
    end
  end

  assign imem_we_o    = r_we;
  assign imem_waddr_o = r_waddr;
  assign imem_wdata_o = r_wdata;
  assign cpu_reset_o  = r_cpu_reset;
  assign done_o       = r_done;
  assign err_o        = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader (either IMEM_LOADER_CHECKSUM_EN build)
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_ready_o;
  logic        start_i;
  logic        imem_we_o;
  logic [31:0] imem_waddr_o;
  logic [31:0] imem_wdata_o;
  logic        cpu_reset_o;
  logic        done_o;
  logic        err_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wr_n = 0;
  int wbase;
  logic [31:0] wr_addr [32];
  logic [31:0] wr_data [32];
  int          wr_cyc  [32];
  logic [31:0] wv [4];

  imem_loader #(.PC_W(32), .INSTR_W(32), .IMEM_DEPTH(1024), .BASE_ADDR(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_valid_i   (rx_valid_i),
    .rx_data_i    (rx_data_i),
    .rx_ready_o   (rx_ready_o),
    .start_i      (start_i),
    .imem_we_o    (imem_we_o),
    .imem_waddr_o (imem_waddr_o),
    .imem_wdata_o (imem_wdata_o),
    .cpu_reset_o  (cpu_reset_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we_o && wr_n < 32) begin
      wr_addr[wr_n] = imem_waddr_o;
      wr_data[wr_n] = imem_wdata_o;
      wr_cyc[wr_n]  = cyc;
      wr_n          = wr_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int guard = 0;
    @(negedge clk);
    while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct && guard < 20) begin
      rx_valid_i = 1'b0;
      @(negedge clk);
      guard++;
    end
    guard = 0;
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    while (!rx_ready_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("byte_accept", rx_ready_o, 1);
    @(posedge clk);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] v, input int gap_pct);
    for (int i = 0; i < 4; i++) begin
      send_byte(v[8*i +: 8], gap_pct);
    end
  endtask

  task automatic load(input int n, input logic [31:0] w [4], input int gap_pct, input logic [31:0] tr_xor);
    logic [31:0] sum;
    sum = 32'd0;
    send_word(32'(n), gap_pct);
    for (int i = 0; i < n; i++) begin
      send_word(w[i], gap_pct);
      chk("wr_strobe", imem_we_o, 1);
      chk("wr_addr", imem_waddr_o, 32'(i));
      chk("wr_data", imem_wdata_o, w[i]);
      sum = sum + w[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(sum ^ tr_xor, gap_pct);
`else
    if (tr_xor != 32'd0) sum = 32'd0;
`endif
  endtask

  task automatic check_done();
    chk("done_t1", done_o, 0);
    chk("cpu_reset_t1", cpu_reset_o, 1);
    @(posedge clk);
    #1;
    chk("done_t2", done_o, 1);
    chk("cpu_reset_t2", cpu_reset_o, 0);
    chk("ready_done", rx_ready_o, 0);
    chk("err_done", err_o, 0);
    chk("we_done", imem_we_o, 0);
  endtask

  task automatic rearm();
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("rearm_done", done_o, 0);
    chk("rearm_err", err_o, 0);
    chk("rearm_cpu_reset", cpu_reset_o, 1);
    chk("rearm_ready", rx_ready_o, 1);
  endtask

  initial begin
    reset      = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    start_i    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", rx_ready_o, 0);
    chk("rst_we", imem_we_o, 0);
    chk("rst_waddr", imem_waddr_o, 0);
    chk("rst_wdata", imem_wdata_o, 0);
    chk("rst_cpu_reset", cpu_reset_o, 1);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", rx_ready_o, 1);

    // Basic three-word image, bytes back to back.
    wbase = wr_n;
    wv = '{32'h00000013, 32'h00100093, 32'hFFF00113, 32'h0};
    load(3, wv, 0, 32'd0);
    check_done();
    chk("t1_wr_count", 32'(wr_n - wbase), 3);
    chk("t1_wr_spacing", 32'(wr_cyc[wbase + 1] - wr_cyc[wbase]), 4);
    chk("t1_wr_addr2", wr_addr[wbase + 2], 2);
    chk("t1_wr_data2", wr_data[wbase + 2], 32'hFFF00113);

    // Oversized header is rejected without writes; stalled bytes in ERR change nothing.
    rearm();
    wbase = wr_n;
    send_word(32'h00000401, 0);
    chk("hdr_err", err_o, 1);
    chk("hdr_err_cpu_reset", cpu_reset_o, 1);
    chk("hdr_err_ready", rx_ready_o, 0);
    @(negedge clk);
    rx_valid_i = 1'b1;
    rx_data_i  = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    rx_valid_i = 1'b0;
    chk("err_hold", err_o, 1);
    chk("err_done_low", done_o, 0);
    chk("err_no_writes", 32'(wr_n - wbase), 0);
    rearm();
    wv = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    load(1, wv, 0, 32'd0);
    check_done();
    chk("t2_wr_count", 32'(wr_n - wbase), 1);

    // Irregular byte arrival.
    rearm();
    wbase = wr_n;
    wv = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
    load(4, wv, 30, 32'd0);
    check_done();
    chk("t3_wr_count", 32'(wr_n - wbase), 4);
    chk("t3_wr_data3", wr_data[wbase + 3], 32'hDDEEFF00);

    // Reset in the middle of a load, then a clean reload.
    rearm();
    send_word(32'd2, 0);
    send_word(32'hAAAAAAAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hBB, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready", rx_ready_o, 0);
    chk("midrst_cpu_reset", cpu_reset_o, 1);
    chk("midrst_we", imem_we_o, 0);
    @(negedge clk);
    reset = 1'b0;
    wbase = wr_n;
    wv = '{32'hCAFEF00D, 32'h0BADC0DE, 32'h0, 32'h0};
    load(2, wv, 0, 32'd0);
    check_done();
    chk("t4_wr_count", 32'(wr_n - wbase), 2);
    chk("t4_wr_addr0", wr_addr[wbase], 0);
    chk("t4_wr_data0", wr_data[wbase], 32'hCAFEF00D);
    chk("t4_wr_addr1", wr_addr[wbase + 1], 1);

    // Empty image.
    rearm();
    wbase = wr_n;
    send_word(32'd0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(32'd0, 0);
    check_done();
    rearm();
    send_word(32'd0, 0);
    send_word(32'd1, 0);
    chk("n0_bad_trailer_err", err_o, 1);
    chk("n0_bad_trailer_cpu_reset", cpu_reset_o, 1);
`else
    check_done();
`endif
    chk("n0_no_writes", 32'(wr_n - wbase), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Trailer must equal the wrapped 32-bit sum.
    rearm();
    wv = '{32'h00000001, 32'hFFFFFFFF, 32'h0, 32'h0};
    load(2, wv, 0, 32'd0);
    check_done();
    rearm();
    load(2, wv, 0, 32'd1);
    chk("csum_mismatch_err", err_o, 1);
    @(posedge clk);
    #1;
    chk("csum_mismatch_cpu_reset", cpu_reset_o, 1);
    chk("csum_mismatch_done", done_o, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
